// File: rtl/fc_pkg.sv
// ---------------------------------------------------------------------------
// fc_pkg
// Purpose : shared constants and types for the fully-connected layer
//           datapath (activation loaders, neuron trees).
// Contents:
//   ACT_WIDTH  default activation width in bits
//   FC1_IN     input vector length of layer FC1
//   FC2_IN     input vector length of layer FC2
//   act_vec_t  one FC1 input vector (ACT_WIDTH x FC1_IN, unpacked)
//   bank_sel_t ping-pong bank selector
//   other_bank returns the opposite ping-pong bank
// ---------------------------------------------------------------------------
package fc_pkg;

    localparam int ACT_WIDTH = 8;
    localparam int FC1_IN    = 128;
    localparam int FC2_IN    = 64;

    typedef logic [ACT_WIDTH-1:0] act_vec_t [FC1_IN];

    typedef logic bank_sel_t;

    function automatic bank_sel_t other_bank(input bank_sel_t sel);
        return ~sel;
    endfunction

endpackage

// File: rtl/fc_act_bank.sv
// ---------------------------------------------------------------------------
// fc_act_bank
// Purpose : one IN x WIDTH register bank for the activation loader. Words are
//           written one at a time and the whole vector is readable at once,
//           so it is built from flops rather than a RAM.
// Ports   :
//   clk      in   clock
//   rst      in   asynchronous active-high reset, clears every word
//   i_we     in   write enable
//   i_widx   in   word index to write
//   i_wdata  in   write data
//   o_rdata  out  full-vector read port (IN words)
// ---------------------------------------------------------------------------
module fc_act_bank
    import fc_pkg::*;
#(
    parameter int WIDTH = ACT_WIDTH,
    parameter int IN    = FC1_IN,
    localparam int IDX_W = $clog2(IN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata [IN]
);

    genvar gi;
    generate
        for (gi = 0; gi < IN; gi++) begin : g_word
            logic [WIDTH-1:0] r_word;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_we && (i_widx == IDX_W'(gi))) begin
                    r_word <= i_wdata;
                end
            end

            assign o_rdata[gi] = r_word;
        end
    endgenerate

endmodule

// File: rtl/fc_act_loader.sv
// ---------------------------------------------------------------------------
// fc_act_loader
// Purpose : serial-to-parallel activation loader in front of an FC layer.
//           Beats arrive over a valid/ready stream and are packed into an
//           IN-element vector. Two ping-pong banks let one vector be filled
//           while the other is presented stable to the layer.
// Ports   :
//   clk       in   clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   upstream beat valid
//   in_ready  out  loader can accept a beat (depends on registers only)
//   in_data   in   activation value
//   in_last   in   final beat of a vector (used only with the framing check)
//   x         out  vector to the FC layer, x[i] = i-th accepted beat
//   x_valid   out  x holds a complete vector
//   x_ready   in   consumer done with x; frees the bank
//   err       out  sticky framing error
// Build option:
//   FC_LOADER_LASTCHK_EN  when defined, in_last is checked against the beat
//                         count; an early last drops the partial vector, a
//                         missing last still commits. Either sets err.
//                         When undefined, framing is by count and err = 0.
// ---------------------------------------------------------------------------
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int WIDTH = ACT_WIDTH,
    parameter int IN    = FC1_IN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] x [IN],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             err
);

    localparam int CNT_W = $clog2(IN);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_full;
    bank_sel_t        r_wr_sel;
    bank_sel_t        r_rd_sel;
    logic             r_err;

    logic             w_accept;
    logic             w_last_beat;
    logic             w_commit;
    logic             w_release;
    logic             w_early_last;
    logic             w_missing_last;
    logic [1:0]       w_full_next;
    logic [WIDTH-1:0] w_bank_data [2][IN];

    assign in_ready    = ~r_full[r_wr_sel];
    assign x_valid     = r_full[r_rd_sel];
    assign err         = r_err;

    assign w_accept    = in_valid & in_ready;
    assign w_last_beat = (r_cnt == CNT_W'(IN - 1));
    assign w_commit    = w_accept & w_last_beat;
    assign w_release   = x_valid & x_ready;

`ifdef FC_LOADER_LASTCHK_EN
    assign w_early_last   = w_accept &  in_last & ~w_last_beat;
    assign w_missing_last = w_accept & ~in_last &  w_last_beat;
`else
    logic w_unused_last;
    assign w_unused_last  = in_last;
    assign w_early_last   = 1'b0;
    assign w_missing_last = 1'b0;
`endif

    // Commit and release can land in the same cycle; they always touch
    // different banks because a commit needs its bank empty and a release
    // needs its bank full.
    always_comb begin
        w_full_next = r_full;
        if (w_release) begin
            w_full_next[r_rd_sel] = 1'b0;
        end
        if (w_commit) begin
            w_full_next[r_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_full   <= 2'b00;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_full <= w_full_next;
            if (w_early_last || w_missing_last) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                if (w_early_last) begin
                    // Partial vector is abandoned; the bank stays free and
                    // the stale words are overwritten by the next fill.
                    r_cnt <= '0;
                end else if (w_last_beat) begin
                    r_cnt    <= '0;
                    r_wr_sel <= other_bank(r_wr_sel);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_rd_sel <= other_bank(r_rd_sel);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            fc_act_bank #(
                .WIDTH (WIDTH),
                .IN    (IN)
            ) u_bank (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_accept && (r_wr_sel == 1'(gi))),
                .i_widx  (r_cnt),
                .i_wdata (in_data),
                .o_rdata (w_bank_data[gi])
            );
        end

        for (gi = 0; gi < IN; gi++) begin : g_xmux
            assign x[gi] = w_bank_data[r_rd_sel][gi];
        end
    endgenerate

endmodule

// File: tb/tb_fc_act_loader.sv
// ---------------------------------------------------------------------------
// tb_fc_act_loader
// Self-checking bench for fc_act_loader (WIDTH=8, IN=128). A queue-based
// reference model tracks the vectors held by the loader; a monitor compares
// the presented vector against the scoreboard queue while x_valid is high
// and pops it on release. Builds with or without FC_LOADER_LASTCHK_EN.
// ---------------------------------------------------------------------------
module tb_fc_act_loader;
    import fc_pkg::*;

    localparam int WIDTH = ACT_WIDTH;
    localparam int IN    = FC1_IN;

`ifdef FC_LOADER_LASTCHK_EN
    localparam bit LASTCHK = 1'b1;
`else
    localparam bit LASTCHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic [WIDTH-1:0] x [IN];
    logic             x_valid;
    logic             x_ready = 1'b0;
    logic             err;

    always #5 clk = ~clk;

    fc_act_loader #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .err      (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_stalls = 0;
    int n_released = 0;
    bit done_flag = 1'b0;

    // Reference model state
    act_vec_t         exp_q[$];
    logic [WIDTH-1:0] part_q[$];
    int               m_held = 0;
    bit               m_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: compare flags, then apply the handshakes the next edge will take.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            part_q.delete();
            m_held = 0;
            m_err  = 1'b0;
        end else begin
            bit acc;
            bit rel;
            check("in_ready", {31'b0, in_ready}, {31'b0, m_held < 2});
            check("x_valid",  {31'b0, x_valid},  {31'b0, m_held > 0});
            check("err",      {31'b0, err},      {31'b0, m_err});
            acc = in_valid && (m_held < 2);
            rel = x_ready && (m_held > 0);
            if (rel) m_held--;
            if (acc) begin
                if (LASTCHK && in_last && part_q.size() != IN - 1) begin
                    m_err = 1'b1;
                    part_q.delete();
                end else begin
                    part_q.push_back(in_data);
                    if (part_q.size() == IN) begin
                        act_vec_t v;
                        if (LASTCHK && !in_last) m_err = 1'b1;
                        for (int k = 0; k < IN; k++) v[k] = part_q[k];
                        exp_q.push_back(v);
                        part_q.delete();
                        m_held++;
                    end
                end
            end
        end
    end

    // Monitor: presented vector must match the scoreboard head.
    always @(posedge clk) begin
        #3;
        if (!rst && x_valid) begin
            if (exp_q.size() == 0) begin
                check("x_queue_nonempty", {31'b0, exp_q.size() > 0}, 32'd1);
            end else begin
                int bad = -1;
                for (int k = 0; k < IN; k++)
                    if (bad < 0 && x[k] !== exp_q[0][k]) bad = k;
                n_checks++;
                if (bad < 0) n_pass++;
                else $display("FAIL x_vec elem %0d: got %0h expected %0h at %0t",
                              bad, x[bad], exp_q[0][bad], $time);
                if (x_ready) begin
                    void'(exp_q.pop_front());
                    n_released++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 2000 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else if (t == 0) n_stalls++;
        end
        if (!ok) check("beat_accept_timeout", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // kind 0: data=i, 1: data=255-i, 2: random
    task automatic send_beats(input int kind, input int n, input int last_idx, input int gap_max);
        for (int i = 0; i < n; i++) begin
            logic [WIDTH-1:0] d;
            if (kind == 0) d = WIDTH'(i);
            else if (kind == 1) d = WIDTH'(255 - i);
            else d = WIDTH'($urandom);
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            send_beat(d, i == last_idx);
        end
    endtask

    task automatic send_vec(input int kind, input int gap_max);
        send_beats(kind, IN, IN - 1, gap_max);
    endtask

    function automatic int count_nonzero_x();
        int c = 0;
        for (int k = 0; k < IN; k++) if (x[k] !== '0) c++;
        return c;
    endfunction

    initial begin
        int rel0;
        int busy;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("reset_x_zero",   count_nonzero_x(), 0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_x_valid",  {31'b0, x_valid},  32'd0);

        // 1: first vector, no release
        send_vec(0, 0);
        check("t1_x_valid",  {31'b0, x_valid}, 32'd1);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        check("t1_x5",   {24'b0, x[5]},   32'd5);
        check("t1_x127", {24'b0, x[127]}, 32'd127);

        // 2: fill second bank, then stall
        send_vec(1, 0);
        check("t2_in_ready", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        busy = 0;
        repeat (10) begin
            tick();
            if (in_ready) busy++;
        end
        in_valid = 1'b0;
        check("t2_no_accept", busy, 0);
        check("t2_x0_held", {24'b0, x[0]}, 32'd0);

        // 3: release bank 0, then bank 1
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
        check("t3_x_valid",  {31'b0, x_valid},  32'd1);
        check("t3_in_ready", {31'b0, in_ready}, 32'd1);
        check("t3_x0",   {24'b0, x[0]},   32'd255);
        check("t3_x127", {24'b0, x[127]}, 32'd128);
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
        check("t3_x_valid_low", {31'b0, x_valid}, 32'd0);

        // 4: streaming with x_ready tied high
        x_ready  = 1'b1;
        n_stalls = 0;
        rel0     = n_released;
        repeat (4) send_vec(2, 0);
        repeat (3) tick();
        check("t4_stalls",   n_stalls, 0);
        check("t4_released", n_released - rel0, 4);

        // 4b: random gaps and random backpressure
        done_flag = 1'b0;
        fork
            begin
                repeat (4) send_vec(2, 2);
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    x_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        x_ready = 1'b1;
        repeat (4) tick();
        x_ready = 1'b0;
        check("t4b_drained", exp_q.size(), 0);

        // 5: reset in the middle of a fill
        send_beats(2, 60, -1, 0);
        rst = 1'b1;
        #1;
        check("t5_x_valid",  {31'b0, x_valid},  32'd0);
        check("t5_in_ready", {31'b0, in_ready}, 32'd1);
        check("t5_x_zero",   count_nonzero_x(), 0);
        tick();
        rst = 1'b0;
        send_vec(0, 1);
        check("t5_x_valid_after", {31'b0, x_valid}, 32'd1);
        check("t5_x0", {24'b0, x[0]}, 32'd0);
        check("t5_x60", {24'b0, x[60]}, 32'd60);
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;

        // 6: framing (early last, good vector, missing last)
        x_ready = 1'b1;
        send_beats(2, 50, 49, 0);
        tick();
        check("t6_err_early", {31'b0, err}, {31'b0, LASTCHK});
        send_vec(2, 0);
        send_beats(2, IN, -1, 0);
        send_beats(2, 78, -1, 0);
        repeat (4) tick();
        check("t6_err_sticky", {31'b0, err}, {31'b0, LASTCHK});
        x_ready = 1'b0;

        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
